// File: rtl/stack_sequencer.sv
// stack_sequencer: expands Forth-style stack operations into
// SmartStack primitive commands, tracking depth and errors.
module stack_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 20,
  parameter int DEPTH_W = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_op_valid,
  output logic               o_op_ready,
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_imm,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_top,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_err_underflow,
  output logic               o_err_overflow,
  output logic               o_err_illegal,
  input  logic               i_err_clear,
  output logic               o_stk_fetch,
  output logic               o_stk_store,
  output logic [2:0]         o_stk_function,
  output logic [WIDTH-1:0]   o_stk_write_D,
  input  logic [WIDTH-1:0]   i_stk_read_A,
  input  logic [WIDTH-1:0]   i_stk_read_B
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_DROP = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4;
  localparam logic [3:0] OP_OVER = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_ROT  = 4'd9;

  localparam logic [2:0] F_NOP  = 3'd0;
  localparam logic [2:0] F_PUSH = 3'd1;
  localparam logic [2:0] F_POP  = 3'd2;
  localparam logic [2:0] F_REPL = 3'd3;
  localparam logic [2:0] F_PREP = 3'd4;
  localparam logic [2:0] F_SWAP = 3'd5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_R1   = 3'd2;
  localparam logic [2:0] S_R2   = 3'd3;
  localparam logic [2:0] S_R3   = 3'd4;
  localparam logic [2:0] S_R4   = 3'd5;
  localparam logic [2:0] S_R5   = 3'd6;
  localparam logic [2:0] S_RESP = 3'd7;

  localparam logic [DEPTH_W:0] LP_DEPTH = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] LP_ONE   = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W:0] LP_TWO   = (DEPTH_W+1)'(2);
  localparam logic [DEPTH_W:0] LP_THREE = (DEPTH_W+1)'(3);

  logic [2:0]         r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_imm;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_c;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_err_uf;
  logic               r_err_of;
  logic               r_err_il;

  logic [DEPTH_W:0]   w_need_d;
  logic [DEPTH_W:0]   w_need_f;
  logic               w_illegal;
  logic               w_accept;
  logic               w_uf;
  logic               w_of;
  logic               w_rej_il;
  logic               w_rej_uf;
  logic               w_rej_of;
  logic [2:0]         w_func;
  logic [WIDTH-1:0]   w_wd;

  // Required depth and free slots per opcode.
  always_comb begin
    w_need_d  = '0;
    w_need_f  = '0;
    w_illegal = 1'b0;
    case (i_op)
      OP_NOP:  ;
      OP_PUSH: w_need_f = LP_ONE;
      OP_DROP: w_need_d = LP_ONE;
      OP_DUP:  begin w_need_d = LP_ONE; w_need_f = LP_ONE; end
      OP_SWAP: w_need_d = LP_TWO;
      OP_OVER: begin w_need_d = LP_TWO; w_need_f = LP_ONE; end
      OP_ADD:  w_need_d = LP_TWO;
      OP_SUB:  w_need_d = LP_TWO;
      OP_AND:  w_need_d = LP_TWO;
      OP_ROT:  w_need_d = LP_THREE;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_accept = i_op_valid & (r_state == S_IDLE);
  assign w_uf     = {1'b0, r_depth} < w_need_d;
  assign w_of     = ({1'b0, r_depth} + w_need_f) > LP_DEPTH;
  assign w_rej_il = w_accept & w_illegal;
  assign w_rej_uf = w_accept & ~w_illegal & w_uf;
  assign w_rej_of = w_accept & ~w_illegal & ~w_uf & w_of;

  always_comb begin
    w_func = F_NOP;
    w_wd   = '0;
    case (r_state)
      S_EXEC: begin
        case (r_op)
          OP_PUSH: begin w_func = F_PUSH; w_wd = r_imm; end
          OP_DROP: w_func = F_POP;
          OP_DUP:  begin w_func = F_PUSH; w_wd = i_stk_read_A; end
          OP_OVER: begin w_func = F_PUSH; w_wd = i_stk_read_B; end
          OP_SWAP: w_func = F_SWAP;
          OP_ADD:  begin
            w_func = F_PREP;
            w_wd   = i_stk_read_B + i_stk_read_A;
          end
          OP_SUB:  begin
            w_func = F_PREP;
            w_wd   = i_stk_read_B - i_stk_read_A;
          end
          OP_AND:  begin
            w_func = F_PREP;
            w_wd   = i_stk_read_B & i_stk_read_A;
          end
          default: ;
        endcase
      end
      S_R1:    w_func = F_POP;
      S_R2:    w_func = F_POP;
      S_R3:    begin w_func = F_REPL; w_wd = r_b; end
      S_R4:    begin w_func = F_PUSH; w_wd = r_c; end
      S_R5:    begin w_func = F_PUSH; w_wd = r_a; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_imm   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= i_op;
          r_imm <= i_imm;
          if (w_illegal || w_uf || w_of || i_op == OP_NOP)
            r_state <= S_RESP;
          else if (i_op == OP_ROT)
            r_state <= S_R1;
          else
            r_state <= S_EXEC;
        end
        S_EXEC: r_state <= S_RESP;
        // ROT (a b c): capture c,b then a as the stack unwinds.
        S_R1: begin
          r_c     <= i_stk_read_A;
          r_b     <= i_stk_read_B;
          r_state <= S_R2;
        end
        S_R2: begin
          r_a     <= i_stk_read_B;
          r_state <= S_R3;
        end
        S_R3:    r_state <= S_R4;
        S_R4:    r_state <= S_R5;
        S_R5:    r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_depth <= '0;
    end else begin
      case (w_func)
        F_PUSH:  r_depth <= r_depth + DEPTH_W'(1);
        F_POP:   r_depth <= r_depth - DEPTH_W'(1);
        F_PREP:  r_depth <= r_depth - DEPTH_W'(1);
        default: ;
      endcase
    end
  end

  // A new error wins over a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
      r_err_il <= 1'b0;
    end else begin
      if (i_err_clear) begin
        r_err_uf <= 1'b0;
        r_err_of <= 1'b0;
        r_err_il <= 1'b0;
      end
      if (w_rej_il) r_err_il <= 1'b1;
      if (w_rej_uf) r_err_uf <= 1'b1;
      if (w_rej_of) r_err_of <= 1'b1;
    end
  end

  assign o_op_ready      = (r_state == S_IDLE);
  assign o_done          = (r_state == S_RESP);
  assign o_top           = i_stk_read_A;
  assign o_depth         = r_depth;
  assign o_err_underflow = r_err_uf;
  assign o_err_overflow  = r_err_of;
  assign o_err_illegal   = r_err_il;
  assign o_stk_fetch     = (w_func != F_NOP);
  assign o_stk_store     = (w_func == F_PUSH) | (w_func == F_REPL) |
                           (w_func == F_PREP);
  assign o_stk_function  = w_func;
  assign o_stk_write_D   = w_wd;

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Controller that sits in front of the CPU data stack (the SmartStack primitive: top/second read ports, write-data port, 3-bit function code). Accepts one Forth-style stack operation at a time over a valid/ready handshake and expands it into one or more primitive stack commands. Tracks stack depth, rejects over- and underflowing or illegal operations without touching the stack, and reports completion with the resulting top of stack.

Parameters:
WIDTH, 16, data word width; must match the stack.
DEPTH, 20, stack capacity in words.
DEPTH_W, 5, width of depth counter; must satisfy 2^DEPTH_W > DEPTH.

Ports:
i_clk  in  1  system clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_op_valid  in  1  operation request valid
o_op_ready  out  1  sequencer can accept an operation (high only in IDLE)
i_op  in  4  opcode: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 ADD, 7 SUB, 8 AND, 9 ROT, 10-15 illegal
i_imm  in  WIDTH  literal for PUSH, sampled with the handshake
o_done  out  1  one-cycle pulse: operation finished or rejected
o_top  out  WIDTH  equals i_stk_read_A; valid whenever o_done=1 and depth>0
o_depth  out  DEPTH_W  current logical depth 0..DEPTH
o_err_underflow  out  1  sticky; set on an operation rejected for underflow
o_err_overflow  out  1  sticky; set on an operation rejected for overflow
o_err_illegal  out  1  sticky; set on an illegal opcode
i_err_clear  in  1  clears all three sticky error flags
o_stk_fetch  out  1  command strobe to stack; high on any cycle issuing a non-NOP function
o_stk_store  out  1  high when the command consumes o_stk_write_D (PUSH, REPLACE, POP_REPLACE)
o_stk_function  out  3  000 NOP, 001 PUSH, 010 POP, 011 REPLACE top, 100 POP_REPLACE (pop, then top:=D), 101 SWAP
o_stk_write_D  out  WIDTH  write data to stack
i_stk_read_A  in  WIDTH  stack top
i_stk_read_B  in  WIDTH  stack second

Behaviour:
- Reset (async): state IDLE, o_op_ready=1, o_done=0, o_depth=0, all error flags 0, o_stk_fetch=0, o_stk_store=0, o_stk_function=NOP, o_stk_write_D=0, temporaries 0. Stack RAM is not cleared; depth 0 makes it logically empty.
- Handshake: accepted on the rising edge where i_op_valid & o_op_ready (cycle T). i_op/i_imm are captured then; they may change afterwards.
- Checks at accept (required depth / free slots): PUSH 0/1, DROP 1/0, DUP 1/1, SWAP 2/0, OVER 2/1, ADD/SUB/AND 2/0, ROT 3/0, NOP 0/0. Underflow has priority over overflow. Illegal opcodes skip checks.
- Rejected op: no stack command is issued (function NOP, strobes low), depth unchanged, matching sticky flag set, state goes to RESP, so o_done pulses in cycle T+1.
- NOP: no stack command; o_done at T+1.
- Single-step ops: EXEC in cycle T+1 drives one command, RESP in T+2 with o_done=1 and o_top updated. Mapping:
  - PUSH: PUSH D=imm.
  - DROP: POP.
  - DUP: PUSH D=A.
  - OVER: PUSH D=B.
  - SWAP: SWAP.
  - ADD: POP_REPLACE D=B+A.
  - SUB: POP_REPLACE D=B-A.
  - AND: POP_REPLACE D=B&A.
  - Arithmetic is modulo 2^WIDTH; carry and borrow are discarded.
- ROT (a b c -- b c a), five command cycles, states R1..R5, each with exactly one command:
  - R1: latch c=A, b=B; POP.
  - R2: latch a=B; POP.
  - R3: REPLACE D=b.
  - R4: PUSH D=c.
  - R5: PUSH D=a.
  - RESP follows, so o_done at T+6.
- Depth updates on the edge ending the command cycle: +1 PUSH, -1 POP/POP_REPLACE, 0 REPLACE/SWAP. Final deltas: PUSH/DUP/OVER +1, DROP/ADD/SUB/AND -1, SWAP/ROT 0.
- RESP always returns to IDLE on the next edge, so o_op_ready rises at T+2 (reject/NOP), T+3 (single-step) or T+7 (ROT). Back-to-back issue therefore has a minimum spacing of 2 cycles.
- Error flags: i_err_clear in the same cycle as a new error leaves the flag set (set wins). Flags never block further operations.
- i_reset during ROT or any op: immediate return to IDLE, depth 0; the partially issued sequence is abandoned.

Test Plan:
- Reset, then PUSH 5, PUSH 7, ADD -> single o_done at T+2 of the ADD with o_top=12, o_depth=1; stack commands seen in order PUSH, PUSH, POP_REPLACE.
- PUSH 1,2,3 then ROT -> o_done 6 cycles after the ROT accept; stack reads 2,3,1 from bottom (o_top=1, i_stk_read_B=3); o_depth=3; exactly 5 strobes on o_stk_fetch.
- Empty stack, DROP -> o_done at T+1, o_err_underflow=1, o_stk_fetch never asserted, o_depth=0. Then SUB on 1-2 -> o_top=16'hFFFF.
- PUSH 20 times, then DUP -> o_err_overflow=1, o_depth stays 20. Then i_err_clear -> flag clears. Opcode 12 -> o_err_illegal=1.
- Assert i_reset in the R3 cycle of a ROT -> o_depth=0, o_op_ready=1, no o_done. A following PUSH 9 gives o_top=9, o_depth=1.
- Hold i_op_valid high continuously with a DUP stream -> one accept per 3 cycles while o_op_ready is low. Pulse i_err_clear together with an underflow reject -> flag ends set.
